// File: rtl/brick_hit_detector.sv
// ---------------------------------------------------------------------------
// brick_hit_detector
//
// Once per frame, walks the brick grid one brick per clock. Each brick that is
// still alive is tested against the ball's bounding box. The first overlap,
// meaning the lowest index, is reported to the brick-state block. The ball
// block is also told which axis to reflect on.
//
// Ports:
//   Clk          in   system clock (the only clock)
//   Reset        in   synchronous, active-high reset
//   frame_clk    in   frame strobe, sampled as data; its rising edge starts a scan
//   BallX/BallY  in   ball centre (10 bits)
//   BallS        in   ball half-size (10 bits)
//   Alive        in   brick alive bitmap, bit index = row*COLS + col
//   BreakX       out  row index of the last hit
//   BreakY       out  column index of the last hit
//   Brick_Broke  out  one-clock pulse marking a hit
//   Bounce_X/Y   out  reflection axis of the last hit, held until the next hit
//   Busy         out  high while a scan is in progress
//   Hit_Count    out  total hits since reset, saturating at 16'hFFFF
// ---------------------------------------------------------------------------
module brick_hit_detector #(
  parameter int ROWS     = 4,
  parameter int COLS     = 8,
  parameter int ORIGIN_X = 32,
  parameter int ORIGIN_Y = 40,
  parameter int BRICK_W  = 64,
  parameter int BRICK_H  = 20,
  parameter int GAP      = 8
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 frame_clk,
  input  logic [9:0]           BallX,
  input  logic [9:0]           BallY,
  input  logic [9:0]           BallS,
  input  logic [ROWS*COLS-1:0] Alive,
  output logic [31:0]          BreakX,
  output logic [31:0]          BreakY,
  output logic                 Brick_Broke,
  output logic                 Bounce_X,
  output logic                 Bounce_Y,
  output logic                 Busy,
  output logic [15:0]          Hit_Count
);

  localparam int NUM   = ROWS * COLS;
  localparam int IDX_W = (NUM > 1) ? $clog2(NUM) : 1;
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);

  typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_t;

  state_t           state_q, state_d;
  logic             frame_q, frame_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [9:0]       ball_x_q, ball_x_d;
  logic [9:0]       ball_y_q, ball_y_d;
  logic [9:0]       ball_s_q, ball_s_d;
  logic [31:0]      break_x_q, break_x_d;
  logic [31:0]      break_y_q, break_y_d;
  logic             brick_broke_q, brick_broke_d;
  logic             bounce_x_q, bounce_x_d;
  logic             bounce_y_q, bounce_y_d;
  logic             busy_q, busy_d;
  logic [15:0]      hit_count_q, hit_count_d;

  logic [10:0] brick_l, brick_r, brick_t, brick_b;
  logic [10:0] ball_l, ball_r, ball_t, ball_b, ball_cx;
  logic        overlap, x_in_span;

  // Geometry of the brick under test and the latched ball box. Everything is
  // widened to 11 bits so that centre + half-size can never wrap. The left
  // and top edges clamp at zero when the half-size exceeds the centre.
  // Row/col are kept as separate counters so no divider is needed.
  always_comb begin
    brick_l = 11'(ORIGIN_X) + 11'(col_q) * 11'(BRICK_W + GAP);
    brick_r = brick_l + 11'(BRICK_W - 1);
    brick_t = 11'(ORIGIN_Y) + 11'(row_q) * 11'(BRICK_H + GAP);
    brick_b = brick_t + 11'(BRICK_H - 1);

    ball_cx = {1'b0, ball_x_q};
    ball_l  = (ball_x_q >= ball_s_q) ? ({1'b0, ball_x_q} - {1'b0, ball_s_q}) : 11'd0;
    ball_r  = {1'b0, ball_x_q} + {1'b0, ball_s_q};
    ball_t  = (ball_y_q >= ball_s_q) ? ({1'b0, ball_y_q} - {1'b0, ball_s_q}) : 11'd0;
    ball_b  = {1'b0, ball_y_q} + {1'b0, ball_s_q};

    overlap   = (ball_l <= brick_r) && (ball_r >= brick_l) &&
                (ball_t <= brick_b) && (ball_b >= brick_t);
    x_in_span = (ball_cx >= brick_l) && (ball_cx <= brick_r);
  end

  // Next-state logic for the scanner. Only IDLE reacts to a frame edge, so an
  // edge arriving during SCAN or REPORT is simply lost. A hit records the
  // result and pulses Brick_Broke from the SCAN cycle. REPORT then spends one
  // cycle so that Busy covers the pulse.
  always_comb begin
    state_d       = state_q;
    frame_d       = frame_clk;
    idx_d         = idx_q;
    row_d         = row_q;
    col_d         = col_q;
    ball_x_d      = ball_x_q;
    ball_y_d      = ball_y_q;
    ball_s_d      = ball_s_q;
    break_x_d     = break_x_q;
    break_y_d     = break_y_q;
    brick_broke_d = 1'b0;
    bounce_x_d    = bounce_x_q;
    bounce_y_d    = bounce_y_q;
    hit_count_d   = hit_count_q;

    case (state_q)
      IDLE: begin
        if (frame_clk && !frame_q) begin
          ball_x_d = BallX;
          ball_y_d = BallY;
          ball_s_d = BallS;
          idx_d    = '0;
          row_d    = '0;
          col_d    = '0;
          state_d  = SCAN;
        end
      end
      SCAN: begin
        if (Alive[idx_q] && overlap) begin
          break_x_d     = 32'(row_q);
          break_y_d     = 32'(col_q);
          bounce_y_d    = x_in_span;
          bounce_x_d    = !x_in_span;
          brick_broke_d = 1'b1;
          if (hit_count_q != 16'hFFFF) hit_count_d = hit_count_q + 16'd1;
          state_d       = REPORT;
        end else if (idx_q == LAST_IDX) begin
          state_d = IDLE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
          if (col_q == LAST_COL) begin
            col_d = '0;
            row_d = row_q + ROW_W'(1);
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end
      end
      REPORT: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // All state, including every output, lives in this one register bank. Reset
  // is synchronous, so asserting it mid-scan or during REPORT lands everything
  // back in IDLE on the next edge. Any pending pulse is dropped.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q       <= IDLE;
      frame_q       <= 1'b0;
      idx_q         <= '0;
      row_q         <= '0;
      col_q         <= '0;
      ball_x_q      <= '0;
      ball_y_q      <= '0;
      ball_s_q      <= '0;
      break_x_q     <= '0;
      break_y_q     <= '0;
      brick_broke_q <= 1'b0;
      bounce_x_q    <= 1'b0;
      bounce_y_q    <= 1'b0;
      busy_q        <= 1'b0;
      hit_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      frame_q       <= frame_d;
      idx_q         <= idx_d;
      row_q         <= row_d;
      col_q         <= col_d;
      ball_x_q      <= ball_x_d;
      ball_y_q      <= ball_y_d;
      ball_s_q      <= ball_s_d;
      break_x_q     <= break_x_d;
      break_y_q     <= break_y_d;
      brick_broke_q <= brick_broke_d;
      bounce_x_q    <= bounce_x_d;
      bounce_y_q    <= bounce_y_d;
      busy_q        <= busy_d;
      hit_count_q   <= hit_count_d;
    end
  end

  assign BreakX      = break_x_q;
  assign BreakY      = break_y_q;
  assign Brick_Broke = brick_broke_q;
  assign Bounce_X    = bounce_x_q;
  assign Bounce_Y    = bounce_y_q;
  assign Busy        = busy_q;
  assign Hit_Count   = hit_count_q;

endmodule

// File: tb/tb_brick_hit_detector.sv
// ---------------------------------------------------------------------------
// tb_brick_hit_detector
//
// Self-checking bench for brick_hit_detector with the default 4x8 grid.
// Each scenario task queues the expected outcome of a frame, then drives the
// frame and watches the DUT for a fixed window. Finally it pops the
// expectation and compares it field by field.
// ---------------------------------------------------------------------------
module tb_brick_hit_detector;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        frame_clk;
  logic [9:0]  BallX, BallY, BallS;
  logic [31:0] Alive;
  logic [31:0] BreakX, BreakY;
  logic        Brick_Broke, Bounce_X, Bounce_Y, Busy;
  logic [15:0] Hit_Count;

  brick_hit_detector dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk),
    .BallX(BallX), .BallY(BallY), .BallS(BallS), .Alive(Alive),
    .BreakX(BreakX), .BreakY(BreakY), .Brick_Broke(Brick_Broke),
    .Bounce_X(Bounce_X), .Bounce_Y(Bounce_Y), .Busy(Busy), .Hit_Count(Hit_Count)
  );

  // Free-running clock, 10 time units per period.
  always #5 Clk = ~Clk;

  typedef struct {
    int          pulses;
    int          cycle;
    int          row;
    int          col;
    bit          bx;
    bit          by;
    int          busy;
    logic [15:0] count;
  } exp_t;

  exp_t        exp_q[$];
  int          vec_count   = 0;
  int          miscompares = 0;
  logic [15:0] model_count = 16'd0;

  int          obs_pulses, obs_cycle, obs_row, obs_col, obs_busy, obs_busy_first, obs_busy_last;
  bit          obs_bx, obs_by;
  logic [15:0] obs_count, obs_final_count;
  logic [31:0] obs_final_row, obs_final_col;

  // Queue the expected outcome of one frame. The hit counter model saturates.
  task automatic push_exp(input int pulses, input int cycle, input int row, input int col,
                          input bit bx, input bit by, input int busy);
    exp_t e;
    if (pulses > 0 && model_count != 16'hFFFF) model_count = model_count + 16'd1;
    e = '{pulses, cycle, row, col, bx, by, busy, model_count};
    exp_q.push_back(e);
  endtask

  // Independent reference for the first hit. It does a plain search in
  // pixel space over the whole grid.
  task automatic model_hit(input int x, input int y, input int s, input logic [31:0] alive,
                           output bit hit, output int k, output int row, output int col, output bit bx);
    int l, r, t, b, gx, gy;
    hit = 0; k = 0; row = 0; col = 0; bx = 0;
    l = (x >= s) ? x - s : 0;  r = x + s;
    t = (y >= s) ? y - s : 0;  b = y + s;
    for (int rr = 0; rr < 4 && !hit; rr++) begin
      for (int cc = 0; cc < 8 && !hit; cc++) begin
        gx = 32 + cc * 72;
        gy = 40 + rr * 28;
        if (alive[rr*8+cc] && l <= gx + 63 && r >= gx && t <= gy + 19 && b >= gy) begin
          hit = 1; k = rr * 8 + cc; row = rr; col = cc;
          bx = !(x >= gx && x <= gx + 63);
        end
      end
    end
  endtask

  // Put the ball on the bus and raise frame_clk. The cycle containing this
  // negedge is cycle t of the frame.
  task automatic start_frame(input int x, input int y, input int s);
    @(negedge Clk);
    BallX = 10'(x); BallY = 10'(y); BallS = 10'(s);
    frame_clk = 1'b1;
  endtask

  // Observe cycles t+1 .. t+ncyc. Optionally add a second frame edge or a
  // Reset pulse at a chosen cycle offset.
  task automatic capture(input int ncyc, input int retrig_at, input int reset_at);
    obs_pulses = 0; obs_cycle = -1; obs_row = -1; obs_col = -1; obs_bx = 0; obs_by = 0;
    obs_busy = 0; obs_busy_first = -1; obs_busy_last = -1; obs_count = 16'hxxxx;
    for (int n = 1; n <= ncyc; n++) begin
      @(negedge Clk);
      if (Brick_Broke) begin
        obs_pulses++;
        if (obs_cycle < 0) begin
          obs_cycle = n; obs_row = int'(BreakX); obs_col = int'(BreakY);
          obs_bx = Bounce_X; obs_by = Bounce_Y; obs_count = Hit_Count;
        end
      end
      if (Busy) begin
        obs_busy++;
        if (obs_busy_first < 0) obs_busy_first = n;
        obs_busy_last = n;
      end
      if (n == 1) frame_clk = 1'b0;
      if (n == retrig_at) frame_clk = 1'b1;
      if (n == retrig_at + 2) frame_clk = 1'b0;
      if (n == reset_at) Reset = 1'b1;
      if (n == reset_at + 1) Reset = 1'b0;
    end
    obs_final_count = Hit_Count;
    obs_final_row   = BreakX;
    obs_final_col   = BreakY;
  endtask

  // Every output must sit at its reset value after Reset is released.
  task automatic test_reset();
    Reset = 1'b1; frame_clk = 1'b0; BallX = '0; BallY = '0; BallS = '0; Alive = '1;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    model_count = 16'd0;
    vec_count++; if ({Busy, Brick_Broke, Bounce_X, Bounce_Y} !== 4'b0000) begin miscompares++; $display("[TB] FAIL reset_flags got %b want 0000", {Busy, Brick_Broke, Bounce_X, Bounce_Y}); end
    vec_count++; if (Hit_Count !== 16'd0) begin miscompares++; $display("[TB] FAIL reset_count got %0d want 0", Hit_Count); end
    vec_count++; if ({BreakX, BreakY} !== 64'd0) begin miscompares++; $display("[TB] FAIL reset_break got %0d/%0d want 0/0", BreakX, BreakY); end
  endtask

  // Centre inside brick (0,0): expect a Y bounce two cycles after the edge.
  task automatic test_direct_hit();
    exp_t e;
    Alive = '1;
    push_exp(1, 2, 0, 0, 0, 1, 2);
    start_frame(68, 50, 4); capture(40, -10, -10);
    e = exp_q.pop_front();
    vec_count++; if (obs_pulses !== e.pulses) begin miscompares++; $display("[TB] FAIL direct_pulses got %0d want %0d", obs_pulses, e.pulses); end
    vec_count++; if (obs_cycle !== e.cycle) begin miscompares++; $display("[TB] FAIL direct_latency got %0d want %0d", obs_cycle, e.cycle); end
    vec_count++; if (obs_row !== e.row || obs_col !== e.col) begin miscompares++; $display("[TB] FAIL direct_rowcol got %0d/%0d want %0d/%0d", obs_row, obs_col, e.row, e.col); end
    vec_count++; if (obs_bx !== e.bx || obs_by !== e.by) begin miscompares++; $display("[TB] FAIL direct_axis got %b%b want %b%b", obs_bx, obs_by, e.bx, e.by); end
    vec_count++; if (obs_count !== e.count) begin miscompares++; $display("[TB] FAIL direct_count got %0d want %0d", obs_count, e.count); end
    vec_count++; if (obs_busy !== e.busy || obs_busy_first !== 1) begin miscompares++; $display("[TB] FAIL direct_busy got %0d from %0d want %0d from 1", obs_busy, obs_busy_first, e.busy); end
  endtask

  // Left edge just touching col 0's last pixel with the centre outside: X bounce.
  task automatic test_side_hit();
    exp_t e;
    Alive = '1;
    push_exp(1, 2, 0, 0, 1, 0, 2);
    start_frame(98, 50, 4); capture(40, -10, -10);
    e = exp_q.pop_front();
    vec_count++; if (obs_pulses !== e.pulses) begin miscompares++; $display("[TB] FAIL side_pulses got %0d want %0d", obs_pulses, e.pulses); end
    vec_count++; if (obs_row !== e.row || obs_col !== e.col) begin miscompares++; $display("[TB] FAIL side_rowcol got %0d/%0d want %0d/%0d", obs_row, obs_col, e.row, e.col); end
    vec_count++; if (obs_bx !== e.bx || obs_by !== e.by) begin miscompares++; $display("[TB] FAIL side_axis got %b%b want %b%b", obs_bx, obs_by, e.bx, e.by); end
    vec_count++; if (obs_count !== e.count) begin miscompares++; $display("[TB] FAIL side_count got %0d want %0d", obs_count, e.count); end
  endtask

  // Ball entirely in the gap, then the side-hit ball with brick 0 dead: no hit.
  task automatic test_gap_and_dead();
    exp_t e;
    Alive = '1;
    push_exp(0, -1, -1, -1, 0, 0, 32);
    start_frame(100, 50, 2); capture(40, -10, -10);
    e = exp_q.pop_front();
    vec_count++; if (obs_pulses !== e.pulses) begin miscompares++; $display("[TB] FAIL gap_pulses got %0d want %0d", obs_pulses, e.pulses); end
    vec_count++; if (obs_busy !== e.busy || obs_busy_first !== 1 || obs_busy_last !== 32) begin miscompares++; $display("[TB] FAIL gap_busy got %0d (%0d..%0d) want %0d (1..32)", obs_busy, obs_busy_first, obs_busy_last, e.busy); end
    vec_count++; if (obs_final_count !== e.count) begin miscompares++; $display("[TB] FAIL gap_count got %0d want %0d", obs_final_count, e.count); end
    Alive = '1; Alive[0] = 1'b0;
    push_exp(0, -1, -1, -1, 0, 0, 32);
    start_frame(98, 50, 4); capture(40, -10, -10);
    e = exp_q.pop_front();
    vec_count++; if (obs_pulses !== e.pulses) begin miscompares++; $display("[TB] FAIL dead_pulses got %0d want %0d", obs_pulses, e.pulses); end
    vec_count++; if (obs_busy !== e.busy) begin miscompares++; $display("[TB] FAIL dead_busy got %0d want %0d", obs_busy, e.busy); end
  endtask

  // Ball spanning col 0 and col 1: only col 0 is reported. Then a hit on the
  // last brick comes out 33 cycles after the edge.
  task automatic test_priority();
    exp_t e;
    Alive = '1;
    push_exp(1, 2, 0, 0, 1, 0, 2);
    start_frame(100, 50, 6); capture(40, -10, -10);
    e = exp_q.pop_front();
    vec_count++; if (obs_pulses !== e.pulses) begin miscompares++; $display("[TB] FAIL prio_pulses got %0d want %0d", obs_pulses, e.pulses); end
    vec_count++; if (obs_row !== e.row || obs_col !== e.col) begin miscompares++; $display("[TB] FAIL prio_rowcol got %0d/%0d want %0d/%0d", obs_row, obs_col, e.row, e.col); end
    push_exp(1, 33, 3, 7, 0, 1, 33);
    start_frame(540, 140, 4); capture(40, -10, -10);
    e = exp_q.pop_front();
    vec_count++; if (obs_cycle !== e.cycle || obs_pulses !== e.pulses) begin miscompares++; $display("[TB] FAIL last_latency got %0d x%0d want %0d x%0d", obs_cycle, obs_pulses, e.cycle, e.pulses); end
    vec_count++; if (obs_row !== e.row || obs_col !== e.col) begin miscompares++; $display("[TB] FAIL last_rowcol got %0d/%0d want %0d/%0d", obs_row, obs_col, e.row, e.col); end
    vec_count++; if (obs_bx !== e.bx || obs_by !== e.by) begin miscompares++; $display("[TB] FAIL last_axis got %b%b want %b%b", obs_bx, obs_by, e.bx, e.by); end
    vec_count++; if (obs_busy !== e.busy) begin miscompares++; $display("[TB] FAIL last_busy got %0d want %0d", obs_busy, e.busy); end
  endtask

  // A second frame edge during SCAN (brick 10 hit) must not cause a second scan.
  task automatic test_back_to_back();
    exp_t e;
    Alive = '1;
    push_exp(1, 12, 1, 2, 0, 1, 12);
    start_frame(200, 78, 4); capture(40, 4, -10);
    e = exp_q.pop_front();
    vec_count++; if (obs_pulses !== e.pulses) begin miscompares++; $display("[TB] FAIL retrig_pulses got %0d want %0d", obs_pulses, e.pulses); end
    vec_count++; if (obs_cycle !== e.cycle) begin miscompares++; $display("[TB] FAIL retrig_latency got %0d want %0d", obs_cycle, e.cycle); end
    vec_count++; if (obs_row !== e.row || obs_col !== e.col) begin miscompares++; $display("[TB] FAIL retrig_rowcol got %0d/%0d want %0d/%0d", obs_row, obs_col, e.row, e.col); end
    vec_count++; if (obs_final_count !== e.count) begin miscompares++; $display("[TB] FAIL retrig_count got %0d want %0d", obs_final_count, e.count); end
  endtask

  // Reset during cycle t+5 of a scan heading for brick 10: no pulse,
  // Busy drops, and all outputs clear.
  task automatic test_reset_mid_scan();
    exp_t e;
    Alive = '1;
    model_count = 16'd0;
    push_exp(0, -1, -1, -1, 0, 0, 5);
    start_frame(200, 78, 4); capture(40, -10, 5);
    e = exp_q.pop_front();
    vec_count++; if (obs_pulses !== e.pulses) begin miscompares++; $display("[TB] FAIL rstscan_pulses got %0d want %0d", obs_pulses, e.pulses); end
    vec_count++; if (obs_busy !== e.busy || obs_busy_last !== 5) begin miscompares++; $display("[TB] FAIL rstscan_busy got %0d last %0d want %0d last 5", obs_busy, obs_busy_last, e.busy); end
    vec_count++; if (obs_final_count !== e.count) begin miscompares++; $display("[TB] FAIL rstscan_count got %0d want %0d", obs_final_count, e.count); end
    vec_count++; if (obs_final_row !== 32'd0 || obs_final_col !== 32'd0) begin miscompares++; $display("[TB] FAIL rstscan_break got %0d/%0d want 0/0", obs_final_row, obs_final_col); end
  endtask

  // Preload the hit counter just below saturation, then hit repeatedly.
  task automatic test_saturation();
    exp_t e;
    Alive = '1;
    @(negedge Clk);
    force dut.hit_count_q = 16'hFFFE;
    repeat (2) @(negedge Clk);
    release dut.hit_count_q;
    model_count = 16'hFFFE;
    for (int i = 0; i < 3; i++) begin
      push_exp(1, 2, 0, 0, 0, 1, 2);
      start_frame(68, 50, 4); capture(40, -10, -10);
      e = exp_q.pop_front();
      vec_count++; if (obs_count !== e.count || obs_pulses !== 1) begin miscompares++; $display("[TB] FAIL sat_count[%0d] got %h x%0d want %h x1", i, obs_count, obs_pulses, e.count); end
    end
  endtask

  // Random alive maps and ball positions, checked against the pixel model.
  task automatic test_random();
    exp_t e;
    bit hit, bx;
    int k, row, col, x, y, s;
    for (int i = 0; i < 10; i++) begin
      Alive = $urandom();
      x = $urandom_range(0, 640); y = $urandom_range(0, 180); s = $urandom_range(1, 24);
      model_hit(x, y, s, Alive, hit, k, row, col, bx);
      if (hit) push_exp(1, k + 2, row, col, bx, !bx, k + 2);
      else     push_exp(0, -1, -1, -1, 0, 0, 32);
      start_frame(x, y, s); capture(40, -10, -10);
      e = exp_q.pop_front();
      vec_count++; if (obs_pulses !== e.pulses || obs_cycle !== e.cycle) begin miscompares++; $display("[TB] FAIL rand[%0d] pulse got x%0d@%0d want x%0d@%0d", i, obs_pulses, obs_cycle, e.pulses, e.cycle); end
      vec_count++; if (obs_row !== e.row || obs_col !== e.col || obs_bx !== e.bx || obs_by !== e.by) begin miscompares++; $display("[TB] FAIL rand[%0d] hit got %0d/%0d %b%b want %0d/%0d %b%b", i, obs_row, obs_col, obs_bx, obs_by, e.row, e.col, e.bx, e.by); end
      vec_count++; if (obs_final_count !== e.count || obs_busy !== e.busy) begin miscompares++; $display("[TB] FAIL rand[%0d] count/busy got %0d/%0d want %0d/%0d", i, obs_final_count, obs_busy, e.count, e.busy); end
    end
  endtask

  // Run every scenario in order, then print the summary.
  initial begin
    test_reset();
    test_direct_hit();
    test_side_hit();
    test_gap_and_dead();
    test_priority();
    test_back_to_back();
    test_reset_mid_scan();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
